// File: rtl/swap_pkg.sv
// Shared state and datapath-select encodings for swap_arbiter.
// SWAP_ARB_SKIP_SAME_EN adds the one-cycle SKIP state and widens the state to 3 bits.
package swap_pkg;

`ifdef SWAP_ARB_SKIP_SAME_EN
   localparam int STATE_W = 3;
`else
   localparam int STATE_W = 2;
`endif

   typedef enum logic [STATE_W-1:0] {
      IDLE = STATE_W'(0),
      PH1  = STATE_W'(1),
      PH2  = STATE_W'(2),
      PH3  = STATE_W'(3)
`ifdef SWAP_ARB_SKIP_SAME_EN
      , SKIP = STATE_W'(4)
`endif
   } state_t;

   typedef enum logic [1:0] {
      SEL_IDLE  = 2'd0,
      SEL_TMP_A = 2'd1,
      SEL_A_B   = 2'd2,
      SEL_B_TMP = 2'd3
   } sel_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr+1, wrapping.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] winner,
   output logic [IDX_W-1:0] win_idx,
   output logic             any
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // Walk the N_REQ candidates in priority order; the first one raised wins.
   always_comb begin
      winner   = '0;
      win_idx  = '0;
      any      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand     = (int'(ptr) + i) % N_REQ;
         cand_idx = IDX_W'(cand);
         if (!any && req[cand_idx]) begin
            any              = 1'b1;
            win_idx          = cand_idx;
            winner           = '0;
            winner[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/swap_arbiter.sv
// Round-robin arbiter sequencing a shared register-file swap datapath (temp<-A, A<-B, B<-temp).
// Define SWAP_ARB_SKIP_SAME_EN to complete same-address swaps in a single SKIP cycle.
module swap_arbiter
   import swap_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 3
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] addr_a,
   input  logic [N_REQ*ADDR_W-1:0] addr_b,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        done,
   output logic [1:0]              sel,
   output logic                    w,
   output logic                    tmp_we,
   output logic                    rf_we,
   output logic [ADDR_W-1:0]       rf_raddr,
   output logic [ADDR_W-1:0]       rf_waddr
);

   localparam int IDX_W = $clog2(N_REQ);

   state_t            state;
   state_t            state_next;
   sel_t              sel_d;
   logic [N_REQ-1:0]  gnt_q;
   logic [ADDR_W-1:0] a_q;
   logic [ADDR_W-1:0] b_q;
   logic [IDX_W-1:0]  ptr;
   logic [N_REQ-1:0]  winner;
   logic [IDX_W-1:0]  win_idx;
   logic              any;
   logic [ADDR_W-1:0] win_a;
   logic [ADDR_W-1:0] win_b;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (req),
      .ptr     (ptr),
      .winner  (winner),
      .win_idx (win_idx),
      .any     (any)
   );

   assign win_a = addr_a[int'(win_idx)*ADDR_W +: ADDR_W];
   assign win_b = addr_b[int'(win_idx)*ADDR_W +: ADDR_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Grant, addresses and pointer are captured only when leaving IDLE; gnt drops with the last cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gnt_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         ptr   <= IDX_W'(N_REQ - 1);
      end else if (state == IDLE && any) begin
         gnt_q <= winner;
         a_q   <= win_a;
         b_q   <= win_b;
         ptr   <= win_idx;
      end else if (state_next == IDLE) begin
         gnt_q <= '0;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (any) begin
`ifdef SWAP_ARB_SKIP_SAME_EN
               state_next = (win_a == win_b) ? SKIP : PH1;
`else
               state_next = PH1;
`endif
            end
         end
         PH1:     state_next = PH2;
         PH2:     state_next = PH3;
         PH3:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Idle addresses keep showing the last latched pair.
   always_comb begin
      sel_d    = SEL_IDLE;
      tmp_we   = 1'b0;
      rf_we    = 1'b0;
      done     = '0;
      rf_raddr = a_q;
      rf_waddr = b_q;
      case (state)
         PH1: begin
            sel_d  = SEL_TMP_A;
            tmp_we = 1'b1;
         end
         PH2: begin
            sel_d    = SEL_A_B;
            rf_raddr = b_q;
            rf_waddr = a_q;
            rf_we    = 1'b1;
         end
         PH3: begin
            sel_d = SEL_B_TMP;
            rf_we = 1'b1;
            done  = gnt_q;
         end
`ifdef SWAP_ARB_SKIP_SAME_EN
         SKIP: begin
            done = gnt_q;
         end
`endif
         default: begin
         end
      endcase
   end

   assign sel = sel_d;
   assign w   = (sel_d != SEL_IDLE);
   assign gnt = gnt_q;

endmodule
